seg_display_sched: RTL and testbench
====================================

// Module: seg_display_sched
// PURPOSE
//  Arbitrates several clients that share one 4-digit 7-segment display. Each
//  granted client's binary value is converted to packed BCD with a serial
//  shift-add-3 (double dabble), replacing per-digit divide/modulo. The block
//  also outputs a leading-zero blank mask. It sits between the game/timer
//  logic and the digit-scan/segment decoder.
// PARAMETERS
//  NREQ  4             number of requesting clients
//  HOLD  32'd50_000_000  clk cycles a result is shown before re-arbitration (>=1)
// PORTS
//  clk        in   1        system clock, all logic on posedge
//  rst_n      in   1        asynchronous active-low reset
//  req        in   NREQ     level request per client
//  num_in     in   NREQ*16  client i value = num_in[16*i+15:16*i], unsigned
//  grant      out  NREQ     one-hot current owner, 0 = none
//  bcd        out  16       [15:12] thousands .. [3:0] units
//  blank      out  4        1 = digit off (leading-zero suppression), bit i = digit i
//  bcd_valid  out  1        1 once any conversion has completed since reset
//  ovf        out  1        last sampled value was >9999 and was clamped
//  busy       out  1        high in LOAD and CONV
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, grant=0, bcd=0, blank=4'b1111,
//   bcd_valid=0, ovf=0, busy=0, round-robin pointer ptr=0, hold counter=0.
//  FSM: IDLE -> LOAD -> CONV -> HOLD -> (LOAD | IDLE).
//  IDLE: if |req, winner = first set req[i] searching i=ptr, ptr+1, .. mod NREQ.
//   On the next edge: grant<=onehot(winner), ptr<=(winner+1)%NREQ, go to LOAD.
//   If no request, stay in IDLE with grant=0. bcd and blank hold their values.
//  LOAD (1 cycle, busy=1): sample num_in of the winner. If the value is >9999,
//   load 9999 and set ovf<=1; otherwise ovf<=0. Clear the 16-bit BCD scratch
//   and the bit counter.
//  CONV (exactly 16 cycles, busy=1): each cycle, add 3 to every scratch nibble
//   >=5, then shift {scratch,bin} left by 1.
//   On the 16th cycle's edge:
//    - bcd<=result, update blank, bcd_valid<=1;
//    - busy<=0, hold counter<=0, go to HOLD.
//   bcd changes exactly 17 edges after grant rises. There is no intermediate
//   update, so the display never glitches.
//  req and num_in are ignored in LOAD and CONV. num_in is sampled only in LOAD.
//  HOLD: the counter increments each cycle.
//   - If the owner's req drops: go to IDLE on the next edge, grant<=0, bcd kept.
//   - When the counter reaches HOLD-1: if |req, re-arbitrate from ptr as in
//     IDLE. grant updates on that edge and the state goes to LOAD. The same
//     client may be regranted, which refreshes its value. If no req, go to IDLE
//     with grant<=0.
//   - Owner drop and counter expiry in the same cycle: the owner-drop rule
//     wins (go to IDLE).
//  blank: blank[3]=(d3==0); blank[2]=blank[3]&(d2==0);
//   blank[1]=blank[2]&(d1==0); blank[0]=0 after the first conversion.
//  Widths: num_in lanes are 16 bits, so the 9999 clamp covers 10000..65535.
//   BCD nibbles are never >9 after conversion.
//  Reset mid-operation (any state): immediate reset values. A partially
//   converted scratch value never reaches bcd.
// TESTING
//  1 rst_n=0 at any time -> grant=0, bcd=0, blank=1111, bcd_valid=0, ovf=0,
//    busy=0.
//  2 req=0001, lane0=1234 -> grant=0001 one edge later; 17 edges later
//    bcd=16'h1234, blank=0000, bcd_valid=1, ovf=0, busy=0.
//  3 lane values 7 / 0 / 10000 / 65535:
//    - 7 -> bcd=0007, blank=1110
//    - 0 -> bcd=0000, blank=1110
//    - 10000 -> bcd=9999, ovf=1
//    - 65535 -> bcd=9999, ovf=1
//  4 HOLD=4, req=1111 held high -> grant sequence 0001,0010,0100,1000,0001.
//    Each grant lasts 1+16+4 cycles.
//  5 Owner 0001 drops req mid-HOLD while req[2]=1 -> next edge grant=0 (IDLE),
//    then grant=0100; bcd keeps the old value until the new conversion ends.
//  6 rst_n pulsed low during CONV, released with req=0 -> reset values persist;
//    no bcd update occurs.

Source files
------------

// File: rtl/seg_display_sched.sv
// Round-robin arbiter that grants a shared 4-digit display to one client at a time,
// converts the client's value to BCD with a serial double-dabble, and derives a leading-zero blank mask.
module seg_display_sched #(
  parameter int          NREQ = 4,
  parameter logic [31:0] HOLD = 32'd50_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*16-1:0] num_in,
  output logic [NREQ-1:0]    grant,
  output logic [15:0]        bcd,
  output logic [3:0]         blank,
  output logic               bcd_valid,
  output logic               ovf,
  output logic               busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CONV, S_HOLD} state_t;

  state_t          state, state_next;
  logic [PW-1:0]   ptr, own;
  logic [15:0]     scratch, bin;
  logic [3:0]      bit_cnt;
  logic [31:0]     hold_cnt;

  logic [2*NREQ-1:0] req_rot;
  logic [NREQ-1:0]   first;
  logic [PW-1:0]     cand    [NREQ];
  logic [PW-1:0]     idx_acc [NREQ+1];
  logic [15:0]       lane_acc[NREQ+1];
  logic [NREQ-1:0]   win_onehot;
  logic [PW-1:0]     win_idx, ptr_next;
  logic              win_found, owner_drop, hold_done, arb, release_grant;
  logic [15:0]       lane, adj, scratch_sh, bin_sh;
  logic [3:0]        blank_new;

  // Rotate requests so bit 0 is the client at ptr; the lowest set bit wins.
  assign req_rot    = {req, req} >> ptr;
  assign idx_acc[0]  = '0;
  assign lane_acc[0] = '0;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_arb
      if (gi == 0) begin : g_first0
        assign first[gi] = req_rot[0];
      end else begin : g_firstn
        assign first[gi] = req_rot[gi] & ~|req_rot[gi-1:0];
      end
      assign cand[gi]       = PW'((int'(ptr) + gi) % NREQ);
      assign idx_acc[gi+1]  = idx_acc[gi] | (first[gi] ? cand[gi] : '0);
      assign win_onehot[gi] = (win_idx == PW'(gi));
      assign lane_acc[gi+1] = lane_acc[gi] | ((own == PW'(gi)) ? num_in[16*gi +: 16] : 16'd0);
    end
  endgenerate

  assign win_idx   = idx_acc[NREQ];
  assign win_found = |req;
  assign ptr_next  = PW'((int'(win_idx) + 1) % NREQ);
  assign lane      = lane_acc[NREQ];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_dd
      assign adj[4*gi +: 4] = (scratch[4*gi +: 4] >= 4'd5) ? scratch[4*gi +: 4] + 4'd3
                                                            : scratch[4*gi +: 4];
    end
  endgenerate

  assign {scratch_sh, bin_sh} = {adj, bin} << 1;

  assign blank_new[3] = (scratch_sh[15:12] == 4'd0);
  assign blank_new[2] = blank_new[3] & (scratch_sh[11:8] == 4'd0);
  assign blank_new[1] = blank_new[2] & (scratch_sh[7:4] == 4'd0);
  assign blank_new[0] = 1'b0;

  assign owner_drop = ~|(req & grant);
  assign hold_done  = (hold_cnt == HOLD - 32'd1);
  assign busy       = (state == S_LOAD) || (state == S_CONV);

  always_comb begin
    state_next    = state;
    arb           = 1'b0;
    release_grant = 1'b0;
    case (state)
      S_IDLE: begin
        if (win_found) begin
          arb        = 1'b1;
          state_next = S_LOAD;
        end
      end
      S_LOAD: state_next = S_CONV;
      S_CONV: if (bit_cnt == 4'd15) state_next = S_HOLD;
      S_HOLD: begin
        // Owner drop takes priority over hold expiry.
        if (owner_drop) begin
          release_grant = 1'b1;
          state_next    = S_IDLE;
        end else if (hold_done) begin
          if (win_found) begin
            arb        = 1'b1;
            state_next = S_LOAD;
          end else begin
            release_grant = 1'b1;
            state_next    = S_IDLE;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      grant     <= '0;
      own       <= '0;
      ptr       <= '0;
      scratch   <= '0;
      bin       <= '0;
      bit_cnt   <= '0;
      hold_cnt  <= '0;
      bcd       <= '0;
      blank     <= 4'b1111;
      bcd_valid <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      state <= state_next;
      if (arb) begin
        grant <= win_onehot;
        own   <= win_idx;
        ptr   <= ptr_next;
      end else if (release_grant) begin
        grant <= '0;
      end
      case (state)
        S_LOAD: begin
          if (lane > 16'd9999) begin
            bin <= 16'd9999;
            ovf <= 1'b1;
          end else begin
            bin <= lane;
            ovf <= 1'b0;
          end
          scratch <= '0;
          bit_cnt <= '0;
        end
        S_CONV: begin
          scratch <= scratch_sh;
          bin     <= bin_sh;
          bit_cnt <= bit_cnt + 4'd1;
          if (bit_cnt == 4'd15) begin
            bcd       <= scratch_sh;
            blank     <= blank_new;
            bcd_valid <= 1'b1;
            hold_cnt  <= '0;
          end
        end
        S_HOLD:  hold_cnt <= hold_cnt + 32'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seg_display_sched.sv
// Scoreboard bench for seg_display_sched: expected conversions are queued when a client
// is driven and compared when busy falls; grant timing is checked cycle by cycle.
module tb_seg_display_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  req = '0;
  logic [63:0] num_in = '0;
  logic [3:0]  grant;
  logic [15:0] bcd;
  logic [3:0]  blank;
  logic        bcd_valid, ovf, busy;

  always #5 clk = ~clk;

  seg_display_sched #(.NREQ(4), .HOLD(32'd4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .num_in(num_in), .grant(grant),
    .bcd(bcd), .blank(blank), .bcd_valid(bcd_valid), .ovf(ovf), .busy(busy)
  );

  typedef struct packed {
    logic [15:0] bcd;
    logic [3:0]  blank;
    logic        ovf;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   vec_cnt = 0;
  int   err_cnt = 0;
  int   conv_seen = 0;
  logic busy_q = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vec_cnt++;
    if (obs !== expv) begin
      err_cnt++;
      $display("FAIL %s: got %h want %h", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input logic [15:0] b, input logic [3:0] bl, input logic o);
    exp_t e;
    e.bcd = b; e.blank = bl; e.ovf = o;
    exp_q.push_back(e);
  endtask

  // Completion monitor: busy falling outside reset marks a finished conversion.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
    end else begin
      busy_q <= busy;
      if (busy_q && !busy) begin
        if (exp_q.size() == 0) begin
          check_val("sb_extra_result", 32'(exp_q.size()), 32'd1);
        end else begin
          mon_e = exp_q.pop_front();
          $display("conv %0d: bcd=%h blank=%b ovf=%b (want %h %b %b)",
                   conv_seen, bcd, blank, ovf, mon_e.bcd, mon_e.blank, mon_e.ovf);
          check_val("sb_bcd", 32'(bcd), 32'(mon_e.bcd));
          check_val("sb_blank", 32'(blank), 32'(mon_e.blank));
          check_val("sb_ovf", 32'(ovf), 32'(mon_e.ovf));
          check_val("sb_valid", 32'(bcd_valid), 32'd1);
        end
        conv_seen <= conv_seen + 1;
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_grant"}, 32'(grant), 32'd0);
    check_val({tag, "_bcd"}, 32'(bcd), 32'd0);
    check_val({tag, "_blank"}, 32'(blank), 32'hF);
    check_val({tag, "_valid"}, 32'(bcd_valid), 32'd0);
    check_val({tag, "_ovf"}, 32'(ovf), 32'd0);
    check_val({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    req   = '0;
    @(negedge clk);
    check_reset_vals("rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_conv(input int target);
    int n = 0;
    while (conv_seen < target && n < 60) begin
      @(negedge clk);
      n++;
    end
    check_val("conv_timeout", 32'(conv_seen >= target), 32'd1);
  endtask

  task automatic do_conv(input logic [15:0] value, input logic [15:0] eb,
                         input logic [3:0] ebl, input logic eo);
    int target;
    @(negedge clk);
    num_in[15:0] = value;
    push_exp(eb, ebl, eo);
    target = conv_seen + 1;
    req = 4'b0001;
    wait_conv(target);
    req = '0;
    repeat (3) @(negedge clk);
    check_val("conv_release_grant", 32'(grant), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] eg;

    // Reset state
    apply_reset();

    // Single client 1234, exact 17-edge latency
    @(negedge clk);
    num_in[15:0] = 16'd1234;
    push_exp(16'h1234, 4'b0000, 1'b0);
    req = 4'b0001;
    @(negedge clk);
    check_val("t2_grant", 32'(grant), 32'h1);
    check_val("t2_busy_load", 32'(busy), 32'd1);
    repeat (16) @(negedge clk);
    check_val("t2_bcd_early", 32'(bcd), 32'd0);
    check_val("t2_busy_conv", 32'(busy), 32'd1);
    @(negedge clk);
    check_val("t2_bcd", 32'(bcd), 32'h1234);
    check_val("t2_blank", 32'(blank), 32'h0);
    check_val("t2_valid", 32'(bcd_valid), 32'd1);
    check_val("t2_busy", 32'(busy), 32'd0);
    req = '0;
    repeat (3) @(negedge clk);

    // Boundary values and clamp
    do_conv(16'd7,     16'h0007, 4'b1110, 1'b0);
    do_conv(16'd0,     16'h0000, 4'b1110, 1'b0);
    do_conv(16'd10000, 16'h9999, 4'b0000, 1'b1);
    do_conv(16'd65535, 16'h9999, 4'b0000, 1'b1);
    do_conv(16'd9999,  16'h9999, 4'b0000, 1'b0);

    // Round robin, all requesting, HOLD=4
    apply_reset();
    @(negedge clk);
    num_in = {16'd12000, 16'd9999, 16'd56, 16'd4321};
    push_exp(16'h4321, 4'b0000, 1'b0);
    push_exp(16'h0056, 4'b1100, 1'b0);
    push_exp(16'h9999, 4'b0000, 1'b0);
    push_exp(16'h9999, 4'b0000, 1'b1);
    push_exp(16'h4321, 4'b0000, 1'b0);
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      eg = 4'b0001 << (g % 4);
      @(negedge clk);
      check_val("rr_grant_start", 32'(grant), 32'(eg));
      repeat (20) @(negedge clk);
      check_val("rr_grant_end", 32'(grant), 32'(eg));
    end
    req = '0;
    repeat (3) @(negedge clk);
    check_val("rr_release", 32'(grant), 32'd0);

    // Owner drop mid-HOLD with another client waiting
    apply_reset();
    @(negedge clk);
    num_in = {16'd0, 16'd88, 16'd0, 16'd321};
    push_exp(16'h0321, 4'b1000, 1'b0);
    push_exp(16'h0088, 4'b1100, 1'b0);
    req = 4'b0101;
    @(negedge clk);
    check_val("drop_grant0", 32'(grant), 32'h1);
    repeat (17) @(negedge clk);
    check_val("drop_bcd0", 32'(bcd), 32'h0321);
    @(negedge clk);
    req = 4'b0100;
    @(negedge clk);
    check_val("drop_idle_grant", 32'(grant), 32'd0);
    check_val("drop_idle_bcd", 32'(bcd), 32'h0321);
    @(negedge clk);
    check_val("drop_grant2", 32'(grant), 32'h4);
    repeat (16) @(negedge clk);
    check_val("drop_bcd_kept", 32'(bcd), 32'h0321);
    @(negedge clk);
    check_val("drop_bcd_new", 32'(bcd), 32'h0088);
    req = '0;
    repeat (3) @(negedge clk);

    // Reset in the middle of a conversion
    apply_reset();
    @(negedge clk);
    num_in[15:0] = 16'd777;
    req = 4'b0001;
    repeat (6) @(negedge clk);
    check_val("midrst_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    req   = '0;
    @(negedge clk);
    check_reset_vals("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    check_reset_vals("postrst");

    check_val("sb_pending", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
